// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state encoding and end-of-scan status codes.
//   state_t   : IDLE / SCAN / DONE controller states
//   status_t  : 2-bit end reason reported on status
package pattern_scan_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_t;
   typedef logic [1:0] status_t;
   localparam status_t ST_BUDGET = 2'b00;
   localparam status_t ST_LIMIT  = 2'b01;
   localparam status_t ST_ABORT  = 2'b10;
endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: host/stream bundle for pattern_scan_ctrl.
//   master drives: start, abort, pattern, budget, hit_limit, din, din_valid
//   slave drives : din_ready, busy, flag, hit_count, done, status
interface pattern_scan_ctrl_if
   import pattern_scan_pkg::*;
   #(parameter int PAT_W = 8, parameter int CNT_W = 8);
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] budget;
   logic [CNT_W-1:0] hit_limit;
   logic             din;
   logic             din_valid;
   logic             din_ready;
   logic             busy;
   logic             flag;
   logic [CNT_W-1:0] hit_count;
   logic             done;
   status_t          status;
   modport master (
      output start, abort, pattern, budget, hit_limit, din, din_valid,
      input  din_ready, busy, flag, hit_count, done, status
   );
   modport slave (
      input  start, abort, pattern, budget, hit_limit, din, din_valid,
      output din_ready, busy, flag, hit_count, done, status
   );
endinterface

// File: rtl/pattern_matcher.sv
// pattern_matcher: sliding PAT_W-bit window with fill tracking and comparator.
//   clk, rst (sync, active-low), clr : clear window and fill count
//   shift_en, din                     : shift din into the window LSB
//   pattern                           : target, MSB compared with oldest bit
//   match                             : combinational, post-shift window hit
module pattern_matcher #(parameter int PAT_W = 8) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);
   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);
   logic [PAT_W-1:0] win, win_nxt;
   logic [FW-1:0]    fill, fill_nxt;
   always_comb begin
      win_nxt  = {win[PAT_W-2:0], din};
      fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
      // Matching looks at the window as it will be after this bit, so a hit
      // is reported on the same edge that accepts the completing bit.
      match    = shift_en && (fill_nxt == FULL) && (win_nxt == pattern);
   end
   always_ff @(posedge clk)
      if (!rst || clr) begin
         win  <= '0;
         fill <= '0;
      end else if (shift_en) begin
         win  <= win_nxt;
         fill <= fill_nxt;
      end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: host-armed serial pattern scanner with budget/limit/abort exits.
//   clk, rst (sync, active-low)
//   bus (slave): start/abort/pattern/budget/hit_limit/din/din_valid in;
//                din_ready/busy/flag/hit_count/done/status out (all registered)
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
   #(parameter int PAT_W = 8, parameter int CNT_W = 8) (
   input logic clk,
   input logic rst,
   pattern_scan_ctrl_if.slave bus
);
   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] bud_q, lim_q, bit_cnt, hits_q, hits_nxt, bits_nxt;
   logic             flag_q, done_q, busy_q, ready_q;
   status_t          status_q, fin_st;
   logic             accept, match, fin;
   assign accept = (state == SCAN) && bus.din_valid;
   pattern_matcher #(.PAT_W(PAT_W)) u_match (
      .clk      (clk),
      .rst      (rst),
      .clr      ((state == IDLE) && bus.start),
      .shift_en (accept),
      .din      (bus.din),
      .pattern  (pat_q),
      .match    (match)
   );
   always_comb begin
      bits_nxt = bit_cnt + 1'b1;
      hits_nxt = (match && hits_q != '1) ? hits_q + 1'b1 : hits_q;
      // Abort wins even when a bit is accepted on the same edge; that bit
      // still counts toward hit_count.
      fin_st   = bus.abort ? ST_ABORT
               : (lim_q != '0 && hits_nxt == lim_q) ? ST_LIMIT : ST_BUDGET;
      fin      = bus.abort ||
                 (accept && ((lim_q != '0 && hits_nxt == lim_q) || bits_nxt == bud_q));
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state    <= IDLE;
         pat_q    <= '0;
         bud_q    <= '0;
         lim_q    <= '0;
         bit_cnt  <= '0;
         hits_q   <= '0;
         status_q <= ST_BUDGET;
         flag_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         flag_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               pat_q    <= bus.pattern;
               bud_q    <= bus.budget;
               lim_q    <= bus.hit_limit;
               bit_cnt  <= '0;
               hits_q   <= '0;
               status_q <= ST_BUDGET;
               busy_q   <= 1'b1;
               ready_q  <= (bus.budget != '0);
               done_q   <= (bus.budget == '0);
               state    <= (bus.budget == '0) ? DONE : SCAN;
            end
            SCAN: begin
               if (accept) begin
                  bit_cnt <= bits_nxt;
                  hits_q  <= hits_nxt;
                  flag_q  <= match;
               end
               if (fin) begin
                  state    <= DONE;
                  status_q <= fin_st;
                  done_q   <= 1'b1;
                  ready_q  <= 1'b0;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   assign bus.din_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.flag      = flag_q;
   assign bus.hit_count = hits_q;
   assign bus.done      = done_q;
   assign bus.status    = status_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: scoreboard bench with a bit-history reference model.
module tb_pattern_scan_ctrl;
   import pattern_scan_pkg::*;
   localparam int PAT_W = 8;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   pattern_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
   pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      bit flag;
      bit done;
      int hits;
      int status;
   } ev_t;
   ev_t exp_q[$];
   bit  stream[$];
   int  checks = 0;
   int  failures = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (bus.flag || bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: flag=%0d done=%0d hits=%0d status=%0d",
                     bus.flag, bus.done, bus.hit_count, bus.status);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("ev_flag", int'(bus.flag), int'(e.flag));
            chk("ev_done", int'(bus.done), int'(e.done));
            chk("ev_hits", int'(bus.hit_count), e.hits);
            chk("ev_status", int'(bus.status), e.status);
         end
      end
   task automatic push_alt(input int n);
      for (int i = 0; i < n; i++) stream.push_back(1'(i % 2));
   endtask
   task automatic push_word(input logic [PAT_W-1:0] x);
      for (int i = PAT_W - 1; i >= 0; i--) stream.push_back(x[i]);
   endtask
   // vpct < 0 gives valid on odd cycles only; cycle indices of -1 disable
   // the abort, stray start and reset injections.
   task automatic do_scan(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] bud,
                          input logic [CNT_W-1:0] lim, input int vpct, input int abort_cyc,
                          input bit abort_bit, input int start_cyc, input int rst_cyc);
      bit hist[$];
      int hits = 0, nbits = 0, cyc = 0, st = ST_BUDGET, st_final = ST_BUDGET;
      bit run, v, b, ab, hit, fin, did_rst = 1'b0;
      logic [PAT_W-1:0] w;
      @(negedge clk);
      bus.start = 1'b1;
      bus.pattern = pat;
      bus.budget = bud;
      bus.hit_limit = lim;
      @(posedge clk);
      run = (bud != 0);
      if (!run) exp_q.push_back('{1'b0, 1'b1, 0, ST_BUDGET});
      @(negedge clk);
      bus.start = 1'b0;
      bus.pattern = PAT_W'($urandom);
      bus.budget = CNT_W'($urandom);
      bus.hit_limit = CNT_W'($urandom);
      chk("busy_after_start", int'(bus.busy), 1);
      chk("ready_after_start", int'(bus.din_ready), int'(run));
      chk("hits_after_start", int'(bus.hit_count), 0);
      while (run && cyc < 2000) begin
         chk("ready_scan", int'(bus.din_ready), 1);
         chk("busy_scan", int'(bus.busy), 1);
         chk("hits_scan", int'(bus.hit_count), hits);
         v  = (vpct < 0) ? bit'(cyc % 2) : ($urandom_range(99) < vpct);
         ab = (cyc == abort_cyc);
         if (ab) v = abort_bit;
         if (cyc == rst_cyc) begin
            v = 1'b0;
            ab = 1'b0;
         end
         b = 1'b0;
         if (v) b = (stream.size() > 0) ? stream.pop_front() : 1'($urandom);
         bus.din = b;
         bus.din_valid = v;
         bus.abort = ab;
         bus.start = (cyc == start_cyc);
         rst = (cyc != rst_cyc);
         @(posedge clk);
         if (cyc == rst_cyc) begin
            run = 1'b0;
            did_rst = 1'b1;
         end else begin
            hit = 1'b0;
            fin = 1'b0;
            if (v) begin
               hist.push_back(b);
               nbits++;
               if (hist.size() >= PAT_W) begin
                  for (int k = 0; k < PAT_W; k++) w[PAT_W-1-k] = hist[hist.size()-PAT_W+k];
                  hit = (w == pat);
               end
               if (hit && hits < MAXC) hits++;
            end
            if (ab) begin
               fin = 1'b1;
               st = ST_ABORT;
            end else if (v && lim != 0 && hits == int'(lim)) begin
               fin = 1'b1;
               st = ST_LIMIT;
            end else if (v && nbits == int'(bud)) begin
               fin = 1'b1;
               st = ST_BUDGET;
            end
            if (hit || fin) exp_q.push_back('{hit, fin, hits, fin ? st : ST_BUDGET});
            if (fin) st_final = st;
            run = !fin;
         end
         @(negedge clk);
         bus.din_valid = 1'b0;
         bus.abort = 1'b0;
         bus.start = 1'b0;
         rst = 1'b1;
         cyc++;
      end
      if (run) begin
         checks++;
         failures++;
         $display("FAIL scan_timeout: still scanning after %0d cycles", cyc);
      end else if (did_rst) begin
         chk("rst_flag", int'(bus.flag), 0);
         chk("rst_done", int'(bus.done), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_ready", int'(bus.din_ready), 0);
         chk("rst_hits", int'(bus.hit_count), 0);
         chk("rst_status", int'(bus.status), 0);
      end else begin
         chk("ready_done", int'(bus.din_ready), 0);
         chk("busy_done", int'(bus.busy), 1);
         chk("hits_final", int'(bus.hit_count), hits);
         @(negedge clk);
         chk("busy_idle", int'(bus.busy), 0);
         chk("ready_idle", int'(bus.din_ready), 0);
         chk("hits_hold", int'(bus.hit_count), hits);
         chk("status_hold", int'(bus.status), st_final);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.pattern = '0;
      bus.budget = '0;
      bus.hit_limit = '0;
      bus.din = 1'b0;
      bus.din_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_flag", int'(bus.flag), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_ready", int'(bus.din_ready), 0);
      chk("reset_hits", int'(bus.hit_count), 0);
      chk("reset_status", int'(bus.status), 0);
      rst = 1'b1;
      stream.delete(); push_alt(16);
      do_scan(8'h55, 8'd16, 8'd0, 100, -1, 1'b0, -1, -1);
      stream.delete(); push_alt(16);
      do_scan(8'h55, 8'd16, 8'd3, 100, -1, 1'b0, -1, -1);
      stream.delete();
      do_scan(8'h55, 8'd0, 8'd0, 100, -1, 1'b0, -1, -1);
      stream.delete(); push_alt(16);
      do_scan(8'h55, 8'd16, 8'd0, 100, -1, 1'b0, 4, -1);
      stream.delete(); push_word(8'hA5);
      do_scan(8'hA5, 8'd8, 8'd0, -1, -1, 1'b0, -1, -1);
      stream.delete(); push_alt(40);
      do_scan(8'h55, 8'd40, 8'd0, 100, 11, 1'b0, -1, -1);
      stream.delete(); push_alt(40);
      do_scan(8'h55, 8'd40, 8'd0, 100, 9, 1'b1, -1, -1);
      stream.delete(); push_word(8'hFF);
      do_scan(8'hFF, 8'd20, 8'd0, 100, -1, 1'b0, -1, 5);
      stream.delete(); push_word(8'hFF);
      do_scan(8'hFF, 8'd8, 8'd0, 100, -1, 1'b0, -1, -1);
      for (int i = 0; i < 25; i++) begin
         logic [PAT_W-1:0] p;
         p = PAT_W'($urandom);
         stream.delete();
         for (int k = 0; k < 8; k++)
            if ($urandom_range(1) == 1) push_word(p);
            else for (int j = 0; j < 3; j++) stream.push_back(1'($urandom));
         do_scan(p, CNT_W'($urandom_range(0, 60)), CNT_W'($urandom_range(0, 4)),
                 int'($urandom_range(40, 100)),
                 ($urandom_range(3) == 0) ? int'($urandom_range(0, 80)) : -1,
                 1'($urandom), -1, -1);
      end
      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
